quad_encoder_reader: RTL



---
 rtl/quad_encoder_reader.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/quad_encoder_reader.sv
// quad_encoder_reader: synchronise, deglitch and 4x-decode an A/B encoder
// into a wrapping position, direction, windowed speed and sticky error.
module quad_encoder_reader #(
  parameter int POS_WIDTH     = 16,
  parameter int FILTER_LEN    = 4,
  parameter int WINDOW_CYCLES = 1000,
  parameter int SPD_WIDTH     = 12
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        enc_a,
  input  logic                        enc_b,
  input  logic                        clear_pos,
  input  logic                        clear_err,
  output logic signed [POS_WIDTH-1:0] position,
  output logic                        dir,
  output logic signed [SPD_WIDTH-1:0] speed,
  output logic                        speed_valid,
  output logic                        err
);

  localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int WW = $clog2(WINDOW_CYCLES);
  localparam logic [FW-1:0] FLIM = FW'(FILTER_LEN - 1);
  localparam logic [WW-1:0] WLIM = WW'(WINDOW_CYCLES - 1);

  typedef enum logic {INIT, RUN} state_t;

  state_t          state;
  logic [1:0]      init_cnt;
  logic            a_s1, a_s2;
  logic            b_s1, b_s2;
  logic [1:0]      filt;
  logic [1:0]      prev;
  logic [FW-1:0]   cnt_a;
  logic [FW-1:0]   cnt_b;
  logic [WW-1:0]   wcnt;
  logic signed [SPD_WIDTH-1:0] acc;

  logic [1:0] idx_cur;
  logic [1:0] idx_old;
  logic [1:0] delta;
  logic       step_fwd;
  logic       step_rev;
  logic       step_bad;

  logic signed [POS_WIDTH-1:0] pos_step;
  logic signed [SPD_WIDTH:0]   spd_step;
  logic signed [SPD_WIDTH:0]   acc_sum;
  logic signed [SPD_WIDTH-1:0] acc_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_s1 <= 1'b0;
      a_s2 <= 1'b0;
      b_s1 <= 1'b0;
      b_s2 <= 1'b0;
    end else begin
      a_s1 <= enc_a;
      a_s2 <= a_s1;
      b_s1 <= enc_b;
      b_s2 <= b_s1;
    end
  end

  // Gray index 00,10,11,01 -> 0..3; index difference gives the step
  assign idx_cur = {filt[0], filt[1] ^ filt[0]};
  assign idx_old = {prev[0], prev[1] ^ prev[0]};
  assign delta   = idx_cur - idx_old;

  always_comb begin
    step_fwd = 1'b0;
    step_rev = 1'b0;
    step_bad = 1'b0;
    if (state == RUN) begin
      unique case (1'b1)
        delta == 2'd1: step_fwd = 1'b1;
        delta == 2'd3: step_rev = 1'b1;
        delta == 2'd2: step_bad = 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    pos_step = '0;
    spd_step = '0;
    if (step_fwd) begin
      pos_step = {{(POS_WIDTH-1){1'b0}}, 1'b1};
      spd_step = {{SPD_WIDTH{1'b0}}, 1'b1};
    end else if (step_rev) begin
      pos_step = '1;
      spd_step = '1;
    end
  end

  always_comb begin
    acc_sum  = {acc[SPD_WIDTH-1], acc} + spd_step;
    acc_next = acc_sum[SPD_WIDTH-1:0];
    if (acc_sum[SPD_WIDTH] != acc_sum[SPD_WIDTH-1]) begin
      acc_next = acc_sum[SPD_WIDTH]
        ? {1'b1, {(SPD_WIDTH-1){1'b0}}}
        : {1'b0, {(SPD_WIDTH-1){1'b1}}};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= INIT;
      init_cnt    <= '0;
      filt        <= '0;
      prev        <= '0;
      cnt_a       <= '0;
      cnt_b       <= '0;
      wcnt        <= '0;
      acc         <= '0;
      position    <= '0;
      dir         <= 1'b0;
      speed       <= '0;
      speed_valid <= 1'b0;
      err         <= 1'b0;
    end else begin
      speed_valid <= 1'b0;
      if (clear_pos) position <= '0;
      if (clear_err) err <= 1'b0;
      unique case (state)
        INIT: begin
          filt     <= {a_s2, b_s2};
          prev     <= {a_s2, b_s2};
          cnt_a    <= '0;
          cnt_b    <= '0;
          init_cnt <= init_cnt + 2'd1;
          if (init_cnt == 2'd2) state <= RUN;
        end
        RUN: begin
          prev <= filt;
          if (a_s2 == filt[1]) begin
            cnt_a <= '0;
          end else if (cnt_a == FLIM) begin
            filt[1] <= a_s2;
            cnt_a   <= '0;
          end else begin
            cnt_a <= cnt_a + FW'(1);
          end
          if (b_s2 == filt[0]) begin
            cnt_b <= '0;
          end else if (cnt_b == FLIM) begin
            filt[0] <= b_s2;
            cnt_b   <= '0;
          end else begin
            cnt_b <= cnt_b + FW'(1);
          end
          // clear_pos beats the step on position, not on dir
          if (step_fwd || step_rev) begin
            dir <= step_rev;
            if (!clear_pos) position <= position + pos_step;
          end
          if (step_bad) err <= 1'b1;
          if (wcnt == WLIM) begin
            wcnt        <= '0;
            speed       <= acc_next;
            acc         <= '0;
            speed_valid <= 1'b1;
          end else begin
            wcnt <= wcnt + WW'(1);
            acc  <= acc_next;
          end
        end
        default: state <= INIT;
      endcase
    end
  end

endmodule
